// File: rtl/e203_exu_regfile_mp.sv
// e203_exu_regfile_mp: flop-based multi-port GPR file with two write ports,
// optional write-to-read bypass and a per-register long-pipe pending scoreboard.
// Ports:
//   clk, rst_n                : clock, synchronous active-low clear
//   rd_idx / rd_dat / rd_busy : NRD packed read ports (index, data, pending flag)
//   wp0_*                     : ALU/commit write port (wins on collision)
//   wp1_*                     : long-pipe writeback port, also clears pending bit
//   lp_set_ena / lp_set_idx   : mark a long-pipe destination as pending
//   x1_r                      : stored x1, never bypassed
//   sb_any                    : OR of all pending bits
module e203_exu_regfile_mp #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NRD*RFIDX_W-1:0] rd_idx,
    output logic [NRD*XLEN-1:0]    rd_dat,
    output logic [NRD-1:0]         rd_busy,
    input  logic                   wp0_ena,
    input  logic [RFIDX_W-1:0]     wp0_idx,
    input  logic [XLEN-1:0]        wp0_dat,
    input  logic                   wp1_ena,
    input  logic [RFIDX_W-1:0]     wp1_idx,
    input  logic [XLEN-1:0]        wp1_dat,
    input  logic                   lp_set_ena,
    input  logic [RFIDX_W-1:0]     lp_set_idx,
    output logic [XLEN-1:0]        x1_r,
    output logic                   sb_any
);

    localparam int NREGS = 2 ** RFIDX_W;

    // x0 has no storage; rf_v presents it as a constant zero entry.
    logic [XLEN-1:0]  rf_q [1:NREGS-1];
    logic [XLEN-1:0]  rf_v [NREGS];
    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_nxt;

    always_comb begin
        rf_v[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            rf_v[i] = rf_q[i];
        end
    end

    // A dispatch on the same index as a writeback clear wins: the register
    // is being reissued to a newer long-pipe op.
    always_comb begin
        sb_nxt    = '0;
        for (int i = 1; i < NREGS; i++) begin
            sb_nxt[i] = (lp_set_ena && (lp_set_idx == RFIDX_W'(i)))
                      | (sb_q[i] && !(wp1_ena && (wp1_idx == RFIDX_W'(i))));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            sb_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wp0_ena && (wp0_idx == RFIDX_W'(i))) begin
                    rf_q[i] <= wp0_dat;
                end else if (wp1_ena && (wp1_idx == RFIDX_W'(i))) begin
                    rf_q[i] <= wp1_dat;
                end
            end
            sb_q <= sb_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RFIDX_W-1:0] idx;
        assign idx        = rd_idx[k*RFIDX_W +: RFIDX_W];
        assign rd_busy[k] = sb_q[idx];

        if (BYPASS != 0) begin : g_byp
            always_comb begin
                rd_dat[k*XLEN +: XLEN] = rf_v[idx];
                if (idx == '0) begin
                    rd_dat[k*XLEN +: XLEN] = '0;
                end else if (wp0_ena && (wp0_idx == idx)) begin
                    rd_dat[k*XLEN +: XLEN] = wp0_dat;
                end else if (wp1_ena && (wp1_idx == idx)) begin
                    rd_dat[k*XLEN +: XLEN] = wp1_dat;
                end
            end
        end else begin : g_nobyp
            assign rd_dat[k*XLEN +: XLEN] = rf_v[idx];
        end
    end

    assign x1_r   = rf_q[1];
    assign sb_any = |sb_q;

endmodule
